serial_xnor_comparator: RTL
===========================

Name: serial_xnor_comparator

Overview:
Bit-serial word equality comparator built around the existing xnor_gatelevel_gate cell. It feeds one bit pair per cycle into an internal xnor_gatelevel_gate instance and consumes that gate's output. From the per-bit results it accumulates a match count, the index of the first mismatching bit, and a final equal flag. It sits between operand registers and control logic that needs a word compare without a parallel WIDTH-wide XNOR tree.

Parameters:
WIDTH, 8, operand width in bits (2..32).
CW, $clog2(WIDTH+1), width of match_count (derived, not overridden).
IW, $clog2(WIDTH), width of mismatch_idx (derived, not overridden).

Ports:
clk  input  1  rising-edge clock, the single clock domain.
rst  input  1  synchronous, active-high reset.
start  input  1  request a compare; sampled only in IDLE.
a_word  input  WIDTH  operand A; latched on accepted start.
b_word  input  WIDTH  operand B; latched on accepted start.
busy  output  1  high in SHIFT and DONE states.
done  output  1  one-cycle pulse; results are valid from this cycle onward.
equal  output  1  1 when all WIDTH bits matched.
match_count  output  CW  number of matching bit positions.
mismatch_valid  output  1  1 when at least one bit differed.
mismatch_idx  output  IW  highest-index (first-seen, MSB-first) differing bit position; 0 when mismatch_valid=0.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset: state=IDLE. busy, done, equal, match_count, mismatch_valid, mismatch_idx all 0. Internal operand registers and bit index cleared.
- Gate usage: exactly one xnor_gatelevel_gate instance. a = a_reg[idx], b = b_reg[idx], out = bit_eq. No other equality logic.
- FSM states:
  - IDLE: busy=0. When start=1, latch a_word/b_word, set idx=WIDTH-1, clear match_count, mismatch_valid, mismatch_idx and equal, then go to SHIFT.
  - SHIFT: busy=1. Each cycle:
    - if bit_eq=1, match_count += 1;
    - if bit_eq=0 and mismatch_valid=0, set mismatch_valid=1 and mismatch_idx=idx;
    - if idx==0, go to DONE; otherwise idx -= 1.
  - DONE: busy=1, done=1 for this single cycle, equal=(match_count==WIDTH). Next state is IDLE unconditionally.
- Latency: start sampled at edge E0 → SHIFT occupies WIDTH cycles → done is high during the cycle following edge E(WIDTH+1). Throughput is one compare per WIDTH+2 cycles.
- start in SHIFT or DONE is ignored; it is not queued. The earliest new start is accepted in the first IDLE cycle after done.
- Operand inputs may change freely after an accepted start; the latched copies are used.
- Results (equal, match_count, mismatch_*) hold their values in IDLE until the next accepted start clears them.
- match_count never exceeds WIDTH. CW is sized so there is no wrap.
- rst asserted in any state, including mid-SHIFT: returns to reset values on that edge. No done pulse is issued for the aborted compare.
- rst and start asserted on the same edge: rst wins; start is ignored.

Test Plan:
- WIDTH=8, a=0xA5, b=0xA5, start pulse → done exactly 9 edges after start edge; equal=1, match_count=8, mismatch_valid=0, mismatch_idx=0; busy high for 9 cycles.
- a=0xA5, b=0x5A → match_count=0, equal=0, mismatch_valid=1, mismatch_idx=7.
- a=0xFF, b=0xFE → match_count=7, equal=0, mismatch_idx=0; then a=0x80, b=0x00 → match_count=7, mismatch_idx=7.
- Start 0xA5/0xA5, then pulse start with 0x00/0xFF at SHIFT cycle 3 and again in the DONE cycle → both ignored; result equal=1, count=8; the next start in IDLE is accepted normally.
- Start 0x0F/0xF0, assert rst at SHIFT cycle 4 → next cycle all outputs 0, state IDLE, no done pulse; a fresh start then completes with correct results.
- Change a_word/b_word every cycle during SHIFT after starting 0x3C/0x3C → still equal=1, match_count=8.

Source files
------------

// File: rtl/serial_xnor_comparator.sv
// Bit-serial word equality comparator: walks both operands MSB-first through a single
// XNOR cell and accumulates match count, first mismatch position and a final equal flag.

module xnor_gatelevel_gate (
    input  logic a,
    input  logic b,
    output logic out
);
    xnor g_xnor (out, a, b);
endmodule

module serial_xnor_comparator #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1),
    localparam int IW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_word,
    input  logic [WIDTH-1:0] b_word,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic [CW-1:0]    match_count,
    output logic             mismatch_valid,
    output logic [IW-1:0]    mismatch_idx
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    logic             r_busy;
    logic             r_done;
    logic             r_equal;
    logic [CW-1:0]    r_match_count;
    logic             r_mismatch_valid;
    logic [IW-1:0]    r_mismatch_idx;

    logic w_a_bit;
    logic w_b_bit;
    logic w_bit_eq;

    assign w_a_bit = r_a[r_idx];
    assign w_b_bit = r_b[r_idx];

    xnor_gatelevel_gate u_xnor (
        .a   (w_a_bit),
        .b   (w_b_bit),
        .out (w_bit_eq)
    );

    // Outputs are registered, so done and the busy drop appear one edge after the DONE state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_a              <= '0;
            r_b              <= '0;
            r_idx            <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_equal          <= 1'b0;
            r_match_count    <= '0;
            r_mismatch_valid <= 1'b0;
            r_mismatch_idx   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a              <= a_word;
                        r_b              <= b_word;
                        r_idx            <= IW'(WIDTH - 1);
                        r_match_count    <= '0;
                        r_mismatch_valid <= 1'b0;
                        r_mismatch_idx   <= '0;
                        r_equal          <= 1'b0;
                        r_busy           <= 1'b1;
                        r_state          <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_bit_eq) begin
                        r_match_count <= r_match_count + CW'(1);
                    end else if (!r_mismatch_valid) begin
                        r_mismatch_valid <= 1'b1;
                        r_mismatch_idx   <= r_idx;
                    end
                    if (r_idx == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx - IW'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_equal <= (r_match_count == CW'(WIDTH));
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign equal          = r_equal;
    assign match_count    = r_match_count;
    assign mismatch_valid = r_mismatch_valid;
    assign mismatch_idx   = r_mismatch_idx;

endmodule
